// File: rtl/accel_frame_fifo.sv
// Multi-channel sample buffer: one FIFO per channel, drained as atomic frames
// (ch0..chN-1, optional sync word) over a valid/ready stream.
module accel_frame_fifo #(
    parameter int                N_CH      = 3,
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 16,
    parameter int                SYNC_EN   = 1,
    parameter logic [DATA_W-1:0] SYNC_WORD = {DATA_W{1'b1}},
    parameter int                OVF_MODE  = 0,
    localparam int               CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_valid,
    output logic              bad_ch,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_is_sync,
    output logic [CNT_W-1:0]  frames_avail,
    output logic [N_CH-1:0]   overflow,
    input  logic              clr_ovf,
    output logic [1:0]        fsm_state
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CH   = 2'd1,
        S_SYNC = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CH_W-1:0] ch_idx, ch_idx_nxt;

    logic [DATA_W-1:0] mem    [N_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [N_CH];
    logic [PTR_W-1:0]  rd_ptr [N_CH];
    logic [CNT_W-1:0]  cnt    [N_CH];

    logic [N_CH-1:0]   push, pop, ovf_set;
    logic              in_ok, accept, all_ready;
    logic [CNT_W-1:0]  min_cnt;
    logic [DATA_W-1:0] head;

    // Stream handshake: a word transfers on a rising edge where out_valid and
    // out_ready are both high; once raised, out_valid and out_data hold until then.
    assign out_valid   = (state != S_IDLE);
    assign out_is_sync = (state == S_SYNC);
    assign accept      = out_valid && out_ready;
    assign in_ok       = in_valid && (int'(in_ch) < N_CH);
    assign fsm_state   = state;

    always_comb begin
        all_ready = 1'b1;
        min_cnt   = FULL_CNT;
        head      = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (cnt[c] == '0) all_ready = 1'b0;
            if (cnt[c] < min_cnt) min_cnt = cnt[c];
            if (int'(ch_idx) == c) head = mem[c][rd_ptr[c]];
        end
    end

    always_comb begin
        case (state)
            S_CH:    out_data = head;
            S_SYNC:  out_data = SYNC_WORD;
            default: out_data = '0;
        endcase
    end

    // A full channel accepts a write only if it is being drained in the same
    // cycle, or (overwrite mode, idle) by discarding its oldest entry.
    always_comb begin
        push    = '0;
        pop     = '0;
        ovf_set = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (state == S_CH && accept && int'(ch_idx) == c) pop[c] = 1'b1;
            if (in_ok && int'(in_ch) == c) begin
                if (cnt[c] != FULL_CNT || pop[c]) begin
                    push[c] = 1'b1;
                end else if (OVF_MODE == 1 && state == S_IDLE) begin
                    push[c]    = 1'b1;
                    pop[c]     = 1'b1;
                    ovf_set[c] = 1'b1;
                end else begin
                    ovf_set[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (push[c]) mem[c][wr_ptr[c]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
            overflow     <= '0;
            bad_ch       <= 1'b0;
            frames_avail <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
                if (push[c] && !pop[c])      cnt[c] <= cnt[c] + 1'b1;
                else if (!push[c] && pop[c]) cnt[c] <= cnt[c] - 1'b1;
            end
            overflow     <= (overflow & ~{N_CH{clr_ovf}}) | ovf_set;
            bad_ch       <= in_valid && (int'(in_ch) >= N_CH);
            frames_avail <= min_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ch_idx <= '0;
        end else begin
            state  <= state_nxt;
            ch_idx <= ch_idx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ch_idx_nxt = ch_idx;
        case (state)
            S_IDLE: begin
                if (all_ready) begin
                    state_nxt  = S_CH;
                    ch_idx_nxt = '0;
                end
            end
            S_CH: begin
                if (accept) begin
                    if (ch_idx == LAST_CH) begin
                        state_nxt  = (SYNC_EN != 0) ? S_SYNC : S_IDLE;
                        ch_idx_nxt = '0;
                    end else begin
                        ch_idx_nxt = ch_idx + 1'b1;
                    end
                end
            end
            S_SYNC: begin
                if (accept) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt  = S_IDLE;
                ch_idx_nxt = '0;
            end
        endcase
    end

endmodule
